// File: rtl/mapper_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mapper_ram_arbiter_if
// Description : CPU, loader and memory-controller signals of the mapper RAM
//               arbiter. The slave modport is the arbiter's view of the bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface mapper_ram_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rnw;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic              ldr_rnw;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rnw;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_refresh;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_rnw, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_addr, ldr_rnw, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output mem_req, mem_addr, mem_rnw, mem_wdata, mem_refresh,
    input  mem_ack, mem_rdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_rnw, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_addr, ldr_rnw, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  mem_req, mem_addr, mem_rnw, mem_wdata, mem_refresh,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mapper_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mapper_ram_arbiter
// Description : Shares the mapper RAM port between the CPU (fixed priority)
//               and the loader, with a starvation guard for the loader.
//               Optional refresh slots: define MAPPER_RAM_ARBITER_REFRESH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mapper_ram_arbiter #(
  parameter int ADDR_W         = 27,
  parameter int DATA_W         = 8,
  parameter int STARVE_MAX     = 4,
  parameter int REFRESH_PERIOD = 390
) (
  input  wire                 clk,
  input  wire                 reset_n,
  mapper_ram_arbiter_if.slave bus,
  output logic                busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CPU  = 2'd1;
  localparam logic [1:0] S_LDR  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rnw_q, mem_rnw_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              ldr_ack_q, ldr_ack_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic idle, starve_full, ref_win, grant_cpu, grant_ldr;

  assign idle        = (state_q == S_IDLE);
  assign starve_full = (starve_cnt_q == 4'(STARVE_MAX));
  // CPU wins contention unless the loader has already been passed over STARVE_MAX times
  assign grant_cpu   = idle && !ref_win && bus.cpu_req && !(bus.ldr_req && starve_full);
  assign grant_ldr   = idle && !ref_win && bus.ldr_req && !grant_cpu;

`ifdef MAPPER_RAM_ARBITER_REFRESH_EN
  localparam logic [1:0] S_REF = 2'd3;
  localparam int         REF_W = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;

  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             ref_pending_q, ref_pending_d;
  logic             mem_refresh_q, mem_refresh_d;
  logic             ref_wrap, ref_done;

  assign ref_win  = ref_pending_q;
  assign ref_wrap = (ref_cnt_q == REF_W'(REFRESH_PERIOD - 1));
  assign ref_done = (state_q == S_REF) && bus.mem_ack;

  // A wrap while a refresh is already pending is simply absorbed
  always_comb begin
    ref_cnt_d     = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
    ref_pending_d = ref_pending_q;
    if (ref_done)      ref_pending_d = 1'b0;
    else if (ref_wrap) ref_pending_d = 1'b1;
    mem_refresh_d = mem_refresh_q;
    if (idle && ref_win) mem_refresh_d = 1'b1;
    if (ref_done)        mem_refresh_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      mem_refresh_q <= 1'b0;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      mem_refresh_q <= mem_refresh_d;
    end
  end

  assign bus.mem_refresh = mem_refresh_q;
`else
  assign ref_win         = 1'b0;
  assign bus.mem_refresh = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (idle) begin
      if (grant_cpu) state_d = S_CPU;
      if (grant_ldr) state_d = S_LDR;
`ifdef MAPPER_RAM_ARBITER_REFRESH_EN
      if (ref_win)   state_d = S_REF;
`endif
    end else if (bus.mem_ack) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.ldr_req || grant_ldr)      starve_cnt_d = 4'd0;
    else if (grant_cpu && !starve_full) starve_cnt_d = starve_cnt_q + 4'd1;

    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_rnw_d   = mem_rnw_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ldr_ack_d   = 1'b0;
    ldr_rdata_d = ldr_rdata_q;

    if (grant_cpu) begin
      mem_req_d   = 1'b1;
      mem_addr_d  = bus.cpu_addr;
      mem_rnw_d   = bus.cpu_rnw;
      mem_wdata_d = bus.cpu_wdata;
    end
    if (grant_ldr) begin
      mem_req_d   = 1'b1;
      mem_addr_d  = bus.ldr_addr;
      mem_rnw_d   = bus.ldr_rnw;
      mem_wdata_d = bus.ldr_wdata;
    end
    // Only the owner of the in-flight transaction sees the completion
    if (!idle && bus.mem_ack) begin
      mem_req_d = 1'b0;
      if (state_q == S_CPU) begin
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = bus.mem_rdata;
      end
      if (state_q == S_LDR) begin
        ldr_ack_d   = 1'b1;
        ldr_rdata_d = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_rnw_q    <= 1'b0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_ack_q    <= 1'b0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_rnw_q    <= mem_rnw_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_ack_q    <= ldr_ack_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rnw   = mem_rnw_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_ack   = ldr_ack_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign busy          = !idle;

endmodule
`default_nettype wire

// File: tb/tb_mapper_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mapper_ram_arbiter
// Description : Self-checking bench for mapper_ram_arbiter: vector table,
//               scoreboard of expected grants/acks, and corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mapper_ram_arbiter;
  localparam int ADDR_W         = 27;
  localparam int DATA_W         = 8;
  localparam int STARVE_MAX     = 4;
  localparam int REFRESH_PERIOD = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  mapper_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mapper_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .REFRESH_PERIOD(REFRESH_PERIOD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy)
  );

  typedef struct {
    logic              who;    // 0 = CPU, 1 = loader
    logic [ADDR_W-1:0] addr;
    logic              rnw;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  typedef struct {
    logic              who;
    logic [ADDR_W-1:0] addr;
    logic              rnw;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                lat;
    int                cycles;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   acks_seen = 0;
  int   refresh_rises = 0;
  bit   saw_refresh = 1'b0;
  bit   prev_ref = 1'b0;
  bit   mem_auto = 1'b1;
  bit   force_ack = 1'b0;
  int   mem_lat = 1;
  int   wait_cnt = 0;

  function automatic logic [7:0] mem_data(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hE5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none at %0t", name, $time);
  endtask

  // Memory controller model: acks mem_lat cycles after the first request cycle
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end else if (force_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h99;
        force_ack     = 1'b0;
      end else if (mem_auto && (bus.mem_req || bus.mem_refresh)) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat + 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_refresh ? 8'h00 : mem_data(bus.mem_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_refresh) saw_refresh = 1'b1;
      if (bus.mem_refresh && !prev_ref) refresh_rises++;
      prev_ref = bus.mem_refresh;
      if (bus.mem_req) begin
        if (sb.size() == 0) fail_now("unexpected_mem_req");
        else begin
          check("mem_addr",  32'(bus.mem_addr),  32'(sb[0].addr));
          check("mem_rnw",   32'(bus.mem_rnw),   32'(sb[0].rnw));
          check("mem_wdata", 32'(bus.mem_wdata), 32'(sb[0].wdata));
        end
      end
      if (bus.cpu_ack || bus.ldr_ack) begin
        if (sb.size() == 0) fail_now("unexpected_ack");
        else begin
          e = sb.pop_front();
          check("ack_src", 32'({bus.cpu_ack, bus.ldr_ack}), e.who ? 32'd1 : 32'd2);
          check("rdata", 32'(e.who ? bus.ldr_rdata : bus.cpu_rdata), 32'(e.rdata));
          acks_seen++;
        end
      end
    end
  end

  task automatic wait_acks(input int target, input int budget, input string name, output int n);
    n = 0;
    while (acks_seen < target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (acks_seen < target) begin
      fail_now(name);
      sb.delete();
    end
  endtask

  task automatic push(input logic who, input logic [ADDR_W-1:0] a, input logic rnw,
                      input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd);
    exp_t e;
    e.who = who; e.addr = a; e.rnw = rnw; e.wdata = wd; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int target;
    mem_lat = v.lat;
    push(v.who, v.addr, v.rnw, v.wdata, v.rdata);
    target = acks_seen + 1;
    if (!v.who) begin
      bus.cpu_addr = v.addr; bus.cpu_rnw = v.rnw; bus.cpu_wdata = v.wdata; bus.cpu_req = 1'b1;
    end else begin
      bus.ldr_addr = v.addr; bus.ldr_rnw = v.rnw; bus.ldr_wdata = v.wdata; bus.ldr_req = 1'b1;
    end
    n = 0;
    while (acks_seen < target && n < 40) begin
      @(posedge clk); #2;
      n++;
      // Requester fields changing after the grant must not reach the memory port
      if (bus.mem_req) begin
        if (!v.who) begin bus.cpu_addr = ~v.addr; bus.cpu_wdata = ~v.wdata; bus.cpu_rnw = ~v.rnw; end
        else        begin bus.ldr_addr = ~v.addr; bus.ldr_wdata = ~v.wdata; bus.ldr_rnw = ~v.rnw; end
      end
    end
    if (acks_seen < target) begin
      fail_now({"timeout_", tag});
      sb.delete();
    end else begin
`ifndef MAPPER_RAM_ARBITER_REFRESH_EN
      check({"latency_", tag}, 32'(n), 32'(v.cycles));
`endif
      check({"busy_after_", tag}, 32'(busy), 32'd0);
    end
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    @(posedge clk); #2;
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int base;
    int t0;
    vecs[0] = '{1'b0, 27'h0004000, 1'b1, 8'h00, 8'hA5, 1, 3};
    vecs[1] = '{1'b1, 27'h0100000, 1'b0, 8'h3C, 8'hE5, 1, 3};
    vecs[2] = '{1'b0, 27'h0001234, 1'b0, 8'h77, 8'hC3, 1, 3};
    vecs[3] = '{1'b1, 27'h7FFFF0F, 1'b1, 8'h00, 8'h15, 3, 5};
    vecs[4] = '{1'b0, 27'h0000000, 1'b1, 8'hFF, 8'hE5, 3, 5};
    vecs[5] = '{1'b1, 27'h00055AA, 1'b1, 8'h12, 8'h1A, 1, 3};

    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_rnw = 1'b1; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_addr = '0; bus.ldr_rnw = 1'b1; bus.ldr_wdata = '0;

    repeat (3) @(posedge clk);
    #2;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_acks",    32'({bus.cpu_ack, bus.ldr_ack}), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_refresh", 32'(bus.mem_refresh), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Contention: both held, grant pattern CPU x STARVE_MAX then loader
    mem_lat = 1;
    bus.cpu_addr = 27'h0002000; bus.cpu_rnw = 1'b1; bus.cpu_wdata = 8'h00;
    bus.ldr_addr = 27'h0300040; bus.ldr_rnw = 1'b0; bus.ldr_wdata = 8'h5E;
    for (int i = 0; i < 10; i++) begin
      if (i % (STARVE_MAX + 1) == STARVE_MAX) push(1'b1, 27'h0300040, 1'b0, 8'h5E, 8'hA5);
      else                                    push(1'b0, 27'h0002000, 1'b1, 8'h00, 8'hC5);
    end
    base = acks_seen;
    bus.cpu_req = 1'b1; bus.ldr_req = 1'b1;
    wait_acks(base + 10, 200, "timeout_contention", n);
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("contention_drained", 32'(sb.size()), 32'd0);

    // Reset while a CPU request is outstanding at the memory
    mem_auto = 1'b0;
    push(1'b0, 27'h0006789, 1'b1, 8'h00, 8'h0B);
    bus.cpu_addr = 27'h0006789; bus.cpu_rnw = 1'b1; bus.cpu_req = 1'b1;
    n = 0;
    while (!bus.mem_req && n < 20) begin @(posedge clk); #2; n++; end
    check("rst_mid_req_seen", 32'(bus.mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_busy",    32'(busy),        32'd0);
    check("rst_mid_acks",    32'({bus.cpu_ack, bus.ldr_ack}), 32'd0);
    sb.delete();
    push(1'b0, 27'h0006789, 1'b1, 8'h00, 8'h0B);
    @(posedge clk); #2;
    reset_n  = 1'b1;
    mem_auto = 1'b1;
    base = acks_seen;
    wait_acks(base + 1, 40, "timeout_after_reset", n);
`ifndef MAPPER_RAM_ARBITER_REFRESH_EN
    check("latency_after_reset", 32'(n), 32'd3);
`endif
    bus.cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Spurious mem_ack while idle
    force_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("spurious_acks", 32'({bus.cpu_ack, bus.ldr_ack}), 32'd0);
`ifndef MAPPER_RAM_ARBITER_REFRESH_EN
      check("spurious_busy", 32'({busy, bus.mem_req}), 32'd0);
`endif
    end
    check("spurious_rdata_held", 32'(bus.cpu_rdata), 32'h0B);

`ifdef MAPPER_RAM_ARBITER_REFRESH_EN
    t0 = refresh_rises;
    n  = 0;
    for (int i = 0; i < 8; i++) begin
      run_vec('{1'b0, 27'(32'h0000100 + i), 1'b1, 8'h00, mem_data(27'(32'h0000100 + i)), 1, 3},
              $sformatf("ref%0d", i));
      n += 5;
    end
    check("refresh_seen", 32'((refresh_rises - t0) >= (n / 16)), 32'd1);
`else
    t0 = 0;
    check("no_refresh", 32'(saw_refresh) + 32'(t0), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

endmodule
`default_nettype wire
